// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite types and constants used by the read master and the read
// slaves on the same bus.
//   resp_t           : AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   rd_state_t       : read-channel FSM states (IDLE/ADDR/DATA/RESP)
//   AXI_PROT_DEFAULT : protection bits driven on AR (unprivileged, secure, data)
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } rd_state_t;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_read_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_read_master
// Single-outstanding AXI4-Lite read initiator. A client word-read request is
// turned into one AR beat followed by one R beat, and the returned data and
// response code are handed back to the client.
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    : client request channel
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_resp                        : client response channel
//   ar_valid/ar_ready/ar_addr/
//   ar_prot                         : AXI read address channel
//   r_valid/r_ready/r_data/r_resp   : AXI read data channel
//
// Build option
//   AXI_RD_ALIGN_CHECK_EN : when defined, a request whose address is not
//   word aligned is answered locally with SLVERR and zero data; no AR issued.
//
// Every output is a decode of registered state or a register itself, so no
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module axi4_lite_read_master
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // client request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    // client response
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    // AXI read address
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [2:0]            ar_prot,
    // AXI read data
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp
);

    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

`ifdef AXI_RD_ALIGN_CHECK_EN
    // Byte-offset bits within one data word; a mask avoids a zero-width
    // slice when DATA_WIDTH is a single byte.
    localparam int                    OFF_W    = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
    logic misaligned;
    assign misaligned = |(req_addr & OFF_MASK);
`endif

    always_comb begin
        state_d    = state_q;
        ar_addr_d  = ar_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ar_addr_d = req_addr;
`ifdef AXI_RD_ALIGN_CHECK_EN
                    if (misaligned) begin
                        rsp_data_d = '0;
                        rsp_resp_d = SLVERR;
                        state_d    = RESP;
                    end else begin
                        state_d = ADDR;
                    end
`else
                    state_d = ADDR;
`endif
                end
            end
            ADDR: begin
                // ar_valid is a pure state decode, so it cannot drop early.
                if (ar_ready) state_d = DATA;
            end
            DATA: begin
                if (r_valid) begin
                    rsp_data_d = r_data;
                    rsp_resp_d = r_resp;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ar_addr_q  <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= OKAY;
        end else begin
            state_q    <= state_d;
            ar_addr_q  <= ar_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign ar_valid  = (state_q == ADDR);
    assign r_ready   = (state_q == DATA);
    assign rsp_valid = (state_q == RESP);
    assign ar_addr   = ar_addr_q;
    assign ar_prot   = AXI_PROT_DEFAULT;
    assign rsp_data  = rsp_data_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_read_master
// Directed scenarios with literal expectations, then randomized traffic. A
// transaction-level model (request taken / address sent / data received)
// predicts the outputs and is compared against the DUT on every falling edge.
// Inputs change 2ns after the rising edge; outputs are checked mid-cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi4_lite_read_master;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BYTES = DW / 8;
`ifdef AXI_RD_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_resp;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_addr;
    logic [2:0]    ar_prot;
    logic          r_valid, r_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_lite_read_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_prot(ar_prot),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A read is a sequence of three events: request taken, address accepted
    // by the bus, data returned; the client then consumes the response.
    logic          m_busy, m_ar_done, m_r_done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [1:0]    m_resp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_ar_done <= 1'b0; m_r_done <= 1'b0;
            m_addr <= '0; m_data <= '0; m_resp <= 2'b00;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_addr <= req_addr;
                if (ALIGN && (int'(req_addr) % BYTES != 0)) begin
                    m_ar_done <= 1'b1; m_r_done <= 1'b1;
                    m_data <= '0; m_resp <= 2'b10;
                end
            end
        end else if (!m_ar_done) begin
            if (ar_ready) m_ar_done <= 1'b1;
        end else if (!m_r_done) begin
            if (r_valid) begin
                m_r_done <= 1'b1; m_data <= r_data; m_resp <= r_resp;
            end
        end else if (rsp_ready) begin
            m_busy <= 1'b0; m_ar_done <= 1'b0; m_r_done <= 1'b0;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req_ready", req_ready, !m_busy);
            chk("m_ar_valid",  ar_valid,  m_busy && !m_ar_done);
            chk("m_r_ready",   r_ready,   m_busy && m_ar_done && !m_r_done);
            chk("m_rsp_valid", rsp_valid, m_busy && m_r_done);
            chk("m_ar_prot",   ar_prot,   3'b000);
            if (m_busy && !m_ar_done) chk("m_ar_addr", ar_addr, m_addr);
            if (m_busy && m_r_done) begin
                chk("m_rsp_data", rsp_data, m_data);
                chk("m_rsp_resp", rsp_resp, m_resp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic quiet();
        req_valid = 0; req_addr = '0; ar_ready = 0; r_valid = 0;
        r_data = '0; r_resp = 2'b00; rsp_ready = 0;
    endtask

    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;

    initial begin
        rst_n = 1'b0;
        quiet();
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_ar_valid",  ar_valid,  1'b0);
        chk("rst_ar_addr",   ar_addr,   '0);
        chk("rst_r_ready",   r_ready,   1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data",  rsp_data,  '0);
        chk("rst_rsp_resp",  rsp_resp,  2'b00);
        cmp_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic read, everything ready
        req_valid = 1; req_addr = 10'h010; ar_ready = 1; r_valid = 1;
        r_data = 32'hDEADBEEF; r_resp = 2'b00; rsp_ready = 1;
        tick();                               // cycle k+1
        req_valid = 0;
        chk("basic_ar_valid", ar_valid, 1'b1);
        chk("basic_ar_addr",  ar_addr,  10'h010);
        tick();                               // k+2
        chk("basic_r_ready",  r_ready,  1'b1);
        tick();                               // k+3
        chk("basic_rsp_valid", rsp_valid, 1'b1);
        chk("basic_rsp_data",  rsp_data,  32'hDEADBEEF);
        chk("basic_rsp_resp",  rsp_resp,  2'b00);
        tick();                               // k+4
        chk("basic_req_ready", req_ready, 1'b1);
        quiet();

        // AR, R and client backpressure in one read
        req_valid = 1; req_addr = 10'h104;
        tick();
        req_valid = 0; req_addr = 10'h3FC;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ar_ready = 1;
            chk("bp_ar_valid", ar_valid, 1'b1);
            chk("bp_ar_addr",  ar_addr,  10'h104);
            if (i < 3) tick();
        end
        tick();
        ar_ready = 0;
        chk("bp_r_ready_rise", r_ready, 1'b1);
        chk("bp_ar_drop",      ar_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_r_ready_hold", r_ready, 1'b1);
        end
        r_valid = 1; r_data = 32'h1234_5678; r_resp = 2'b01;
        tick();
        r_valid = 0; r_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data",  rsp_data,  32'h1234_5678);
            chk("bp_rsp_resp",  rsp_resp,  2'b01);
            chk("bp_req_ready", req_ready, 1'b0);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("bp_done", req_ready, 1'b1);
        quiet();

        // error pass-through
        req_valid = 1; req_addr = 10'h0F0; ar_ready = 1; r_valid = 1;
        r_data = 32'h0; r_resp = 2'b11; rsp_ready = 1;
        tick(); req_valid = 0;
        tick(); tick();
        chk("err_rsp_valid", rsp_valid, 1'b1);
        chk("err_rsp_resp",  rsp_resp,  2'b11);
        chk("err_rsp_data",  rsp_data,  32'h0);
        tick();
        chk("err_idle", req_ready, 1'b1);
        quiet();

        // misaligned request
        req_valid = 1; req_addr = 10'h003; ar_ready = 1; r_valid = 1;
        r_data = 32'hCAFE_F00D; rsp_ready = 0;
        tick(); req_valid = 0;
        if (ALIGN) begin
            chk("mis_ar_valid",  ar_valid,  1'b0);
            chk("mis_rsp_valid", rsp_valid, 1'b1);
            chk("mis_rsp_resp",  rsp_resp,  2'b10);
            chk("mis_rsp_data",  rsp_data,  32'h0);
        end else begin
            chk("mis_ar_valid", ar_valid, 1'b1);
            chk("mis_ar_addr",  ar_addr,  10'h003);
        end
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("mis_idle", req_ready, 1'b1);
        quiet();

        // reset while waiting for R data
        req_valid = 1; req_addr = 10'h044; ar_ready = 1;
        tick(); req_valid = 0;
        tick();
        chk("rstm_in_data", r_ready, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstm_ar_valid",  ar_valid,  1'b0);
        chk("rstm_r_ready",   r_ready,   1'b0);
        chk("rstm_rsp_valid", rsp_valid, 1'b0);
        chk("rstm_req_ready", req_ready, 1'b1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        req_valid = 1; req_addr = 10'h020; ar_ready = 1; r_valid = 1;
        r_data = 32'hA5A5_0020; r_resp = 2'b00; rsp_ready = 1;
        tick(); req_valid = 0;
        chk("rstm_new_addr", ar_addr, 10'h020);
        tick(); tick();
        chk("rstm_new_rsp",  rsp_valid, 1'b1);
        chk("rstm_new_data", rsp_data,  32'hA5A5_0020);
        tick();
        quiet();

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = AW'($urandom);
            if ($urandom_range(0, 1) == 0) req_addr[1:0] = 2'b00;
            ar_ready  = ($urandom_range(0, 2) != 0);
            r_valid   = ($urandom_range(0, 2) != 0);
            r_data    = $urandom;
            r_resp    = 2'($urandom_range(0, 3));
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        quiet();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
